// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-and-add multiplier for mult/multu: one partial-product step per RUN cycle,
// sign correction on the way out of DONE, and a start/busy/done handshake to the stall logic.
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     upper_sum, upper_next;
    logic [2*WIDTH-1:0] prod_step, prod_fixed;

    assign neg_a_in = is_signed_i & op_a_i[WIDTH-1];
    assign neg_b_in = is_signed_i & op_b_i[WIDTH-1];
    assign abs_a    = neg_a_in ? (~op_a_i + 1'b1) : op_a_i;
    assign abs_b    = neg_b_in ? (~op_b_i + 1'b1) : op_b_i;

    // Carry out of the upper-half add becomes the new MSB after the shift.
    assign upper_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    assign upper_next = prod_q[0] ? upper_sum : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    assign prod_step  = {upper_next, prod_q[WIDTH-1:1]};
    assign prod_fixed = (sign_a_q ^ sign_b_q) ? (~prod_q + 1'b1) : prod_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mag_a_d  = mag_a_q;
        prod_d   = prod_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    sign_a_d = neg_a_in;
                    sign_b_d = neg_b_in;
                    mag_a_d  = abs_a;
                    prod_d   = {{WIDTH{1'b0}}, abs_b};
                    count_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                prod_d  = prod_step;
                count_d = count_q + CW'(1);
                busy_d  = 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                {hi_d, lo_d} = prod_fixed;
                done_d       = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mag_a_q  <= '0;
            prod_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mag_a_q  <= mag_a_d;
            prod_q   <= prod_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: a schedule-level product model checked every cycle,
// plus hand-computed literal results and latencies for each directed operation.
module tb_seq_mult_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          is_signed_i = 1'b0;
    logic [W-1:0]  op_a_i = '0;
    logic [W-1:0]  op_b_i = '0;
    logic          busy_o, done_o;
    logic [W-1:0]  hi_o, lo_o;

    int vectors = 0;
    int miscompares = 0;

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .is_signed_i(is_signed_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] ref_product(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes exactly LAT edges later; busy spans the request.
    int          edge_n = 0;
    bit          m_active = 0;
    bit          m_done = 0;
    int          m_tstart = 0;
    logic [63:0] m_pending = '0;
    logic [63:0] m_res = '0;

    always @(posedge clk_i) begin
        edge_n++;
        m_done = 0;
        if (reset_i) begin
            m_active = 0;
            m_res    = '0;
        end else if (!m_active) begin
            if (start_i) begin
                m_active  = 1;
                m_tstart  = edge_n;
                m_pending = ref_product(is_signed_i, op_a_i, op_b_i);
            end
        end else if (edge_n == m_tstart + LAT) begin
            m_active = 0;
            m_res    = m_pending;
            m_done   = 1;
        end
    end

    always @(negedge clk_i) begin
        chk("busy", {63'b0, busy_o}, {63'b0, m_active});
        chk("done", {63'b0, done_o}, {63'b0, m_done});
        chk("hilo", {hi_o, lo_o}, m_res);
    end

    // Issues one request, optionally pokes a second start mid-run, and checks latency and result.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int poke_at,
                          input string name);
        int lat;
        bit seen;
        #1;
        start_i = 1'b1; is_signed_i = sgn; op_a_i = a; op_b_i = b;
        @(negedge clk_i);
        #1;
        start_i = 1'b0; is_signed_i = ~sgn; op_a_i = ~a; op_b_i = b ^ 32'h5A5A_A5A5;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk_i);
            lat++;
            if (done_o) seen = 1;
            else if (i == poke_at) begin
                #1; start_i = 1'b1; is_signed_i = 1'b0; op_a_i = 32'd9; op_b_i = 32'd9;
            end else if (i == poke_at + 1) begin
                #1; start_i = 1'b0;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(LAT));
        chk({name, "_hi"}, {32'b0, hi_o}, {32'b0, eh});
        chk({name, "_lo"}, {32'b0, lo_o}, {32'b0, el});
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("reset_busy", {63'b0, busy_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        #1 reset_i = 1'b0;
        @(negedge clk_i);

        run_op(1'b0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 0, "multu_7x6");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, "multu_max");
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, "mult_m3x5");
        run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 0, "multu_m3x5");
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, "mult_min_sq");
        run_op(1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0, "mult_min_x1");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A, 0, "mult_neg_neg");
        run_op(1'b1, 32'd0, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 0, "mult_zero");
        run_op(1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 4, "multu_3x4_poke");
        run_op(1'b0, 32'd9, 32'd9, 32'h0000_0000, 32'h0000_0051, 0, "multu_9x9_b2b");

        run_op(1'b0, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 0, "multu_42");
        #1;
        start_i = 1'b1; is_signed_i = 1'b0; op_a_i = 32'd2; op_b_i = 32'd3;
        @(negedge clk_i);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        #1 reset_i = 1'b1;
        @(negedge clk_i);
        chk("midrun_reset_busy", {63'b0, busy_o}, 64'd0);
        chk("midrun_reset_done", {63'b0, done_o}, 64'd0);
        chk("midrun_reset_hilo", {hi_o, lo_o}, 64'd0);
        #1 reset_i = 1'b0;
        repeat (40) @(negedge clk_i);
        chk("post_reset_hilo", {hi_o, lo_o}, 64'd0);
        run_op(1'b0, 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 0, "multu_2x2");

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
